// File: rtl/hb_iodev_ctrl.sv
// hb_iodev_ctrl: I/O window decode, output registers and input FIFOs for the Hummingbird CPU.
// Define HB_IODEV_IRQ_EN to add the irq output and the interrupt mask register at offset 14.
module hb_iodev_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 12,
    parameter int NUM_ODEV    = 3,
    parameter int NUM_IDEV    = 1,
    parameter int IFIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          io_address,
    input  logic                       csram_bar,
    input  logic                       weram_bar,
    input  logic                       bootloader_done,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rdata_oe,
    output logic                       ram_sel,
    output logic [NUM_ODEV*DATA_W-1:0] odev_data,
    output logic [NUM_ODEV-1:0]        odev_strobe,
    input  logic [NUM_IDEV*DATA_W-1:0] idev_data,
    input  logic [NUM_IDEV-1:0]        idev_valid,
    output logic [NUM_IDEV-1:0]        idev_ready
`ifdef HB_IODEV_IRQ_EN
    ,
    output logic                       irq
`endif
);
    localparam int PTR_W = $clog2(IFIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam int UFLOW_BIT = 7;
    localparam logic [3:0] OFF_STATUS = 4'd15;
`ifdef HB_IODEV_IRQ_EN
    localparam logic [3:0] OFF_MASK = 4'd14;
`endif

    logic                window_s;
    logic                io_hit_s;
    logic                first_s;
    logic                end_s;
    logic                wr_commit_s;
    logic                rd_done_s;
    logic [3:0]          offset_s;
    logic [DATA_W-1:0]   live_rdata_s;
    logic [DATA_W-1:0]   status_s;
    logic                live_empty_s;
    logic [NUM_IDEV-1:0] empty_s;
    logic [NUM_IDEV-1:0] full_s;
    logic [NUM_IDEV-1:0] push_s;
    logic [NUM_IDEV-1:0] pop_s;
    logic [DATA_W-1:0]   head_s [NUM_IDEV];

    logic                               in_access_q, in_access_d;
    logic                               acc_hit_q, acc_hit_d;
    logic                               acc_rd_q, acc_rd_d;
    logic                               acc_empty_q, acc_empty_d;
    logic [3:0]                         acc_off_q, acc_off_d;
    logic [DATA_W-1:0]                  rdata_q, rdata_d;
    logic [NUM_ODEV-1:0][DATA_W-1:0]    odev_q, odev_d;
    logic [NUM_ODEV-1:0]                strobe_q, strobe_d;
    logic                               underflow_q, underflow_d;
    logic [PTR_W-1:0]                   wr_ptr_q [NUM_IDEV];
    logic [PTR_W-1:0]                   wr_ptr_d [NUM_IDEV];
    logic [PTR_W-1:0]                   rd_ptr_q [NUM_IDEV];
    logic [PTR_W-1:0]                   rd_ptr_d [NUM_IDEV];
    logic [DATA_W-1:0]                  fifo_mem_q [NUM_IDEV][IFIFO_DEPTH];
    logic [DATA_W-1:0]                  fifo_mem_d [NUM_IDEV][IFIFO_DEPTH];
`ifdef HB_IODEV_IRQ_EN
    logic [DATA_W-1:0]                  mask_q, mask_d;
    logic                               irq_q, irq_d;
    assign irq = irq_q;
`endif

    assign window_s    = &io_address[ADDR_W-1:4];
    assign offset_s    = io_address[3:0];
    assign io_hit_s    = !csram_bar && window_s && bootloader_done;
    assign ram_sel     = !csram_bar && (!window_s || !bootloader_done);
    assign first_s     = !csram_bar && !in_access_q;
    assign end_s       = csram_bar && in_access_q;
    assign wr_commit_s = first_s && io_hit_s && !weram_bar;
    assign rd_done_s   = end_s && acc_hit_q && acc_rd_q;
    assign rdata_oe    = io_hit_s && weram_bar;
    // After the first cycle the captured value is shown so a long read cannot change under the CPU.
    assign rdata       = rdata_oe ? (in_access_q ? rdata_q : live_rdata_s) : '0;
    assign odev_data   = odev_q;
    assign odev_strobe = strobe_q;

    // FIFO occupancy flags, heads and producer handshake.
    always_comb begin
        for (int k = 0; k < NUM_IDEV; k++) begin
            empty_s[k]    = (wr_ptr_q[k] == rd_ptr_q[k]);
            full_s[k]     = (wr_ptr_q[k][PTR_W-1] != rd_ptr_q[k][PTR_W-1]) &&
                            (wr_ptr_q[k][IDX_W-1:0] == rd_ptr_q[k][IDX_W-1:0]);
            head_s[k]     = fifo_mem_q[k][rd_ptr_q[k][IDX_W-1:0]];
            idev_ready[k] = !full_s[k];
            push_s[k]     = idev_valid[k] && !full_s[k];
        end
    end

    // Combinational read mux for the live address.
    always_comb begin
        status_s = '0;
        for (int k = 0; k < NUM_IDEV; k++) begin
            status_s[k] = !empty_s[k];
        end
        status_s[UFLOW_BIT] = underflow_q;
        live_rdata_s = '0;
        live_empty_s = 1'b0;
        for (int i = 0; i < NUM_ODEV; i++) begin
            live_rdata_s = (offset_s == 4'(i)) ? odev_q[i] : live_rdata_s;
        end
        for (int k = 0; k < NUM_IDEV; k++) begin
            live_rdata_s = (offset_s == 4'(8 + k)) ? (empty_s[k] ? '0 : head_s[k]) : live_rdata_s;
            live_empty_s = (offset_s == 4'(8 + k)) ? empty_s[k] : live_empty_s;
        end
        case (offset_s)
            OFF_STATUS: live_rdata_s = status_s;
`ifdef HB_IODEV_IRQ_EN
            OFF_MASK:   live_rdata_s = mask_q;
`endif
            default:    live_rdata_s = live_rdata_s;
        endcase
    end

    // Next-state: access capture, register writes, underflow and FIFO pointers.
    always_comb begin
        in_access_d = !csram_bar;
        if (first_s) begin
            acc_hit_d   = io_hit_s;
            acc_rd_d    = weram_bar;
            acc_off_d   = offset_s;
            acc_empty_d = live_empty_s;
            rdata_d     = live_rdata_s;
        end else begin
            acc_hit_d   = acc_hit_q;
            acc_rd_d    = acc_rd_q;
            acc_off_d   = acc_off_q;
            acc_empty_d = acc_empty_q;
            rdata_d     = rdata_q;
        end
        for (int i = 0; i < NUM_ODEV; i++) begin
            odev_d[i]   = (wr_commit_s && (offset_s == 4'(i))) ? wdata : odev_q[i];
            strobe_d[i] = wr_commit_s && (offset_s == 4'(i));
        end
        if (wr_commit_s && (offset_s == OFF_STATUS) && wdata[UFLOW_BIT]) begin
            underflow_d = 1'b0;
        end else if (rd_done_s && acc_empty_q) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
        fifo_mem_d = fifo_mem_q;
        for (int k = 0; k < NUM_IDEV; k++) begin
            pop_s[k]    = rd_done_s && !acc_empty_q && (acc_off_q == 4'(8 + k));
            wr_ptr_d[k] = wr_ptr_q[k] + {{(PTR_W-1){1'b0}}, push_s[k]};
            rd_ptr_d[k] = rd_ptr_q[k] + {{(PTR_W-1){1'b0}}, pop_s[k]};
            for (int j = 0; j < IFIFO_DEPTH; j++) begin
                fifo_mem_d[k][j] = (push_s[k] && (wr_ptr_q[k][IDX_W-1:0] == IDX_W'(j))) ?
                                   idev_data[k*DATA_W +: DATA_W] : fifo_mem_q[k][j];
            end
        end
`ifdef HB_IODEV_IRQ_EN
        if (wr_commit_s && (offset_s == OFF_MASK)) begin
            mask_d = wdata;
        end else begin
            mask_d = mask_q;
        end
        irq_d = |(~empty_s & mask_q[NUM_IDEV-1:0]);
`endif
    end

    // State registers; an access still in progress at reset is marked as a dead non-hit access.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_access_q <= !csram_bar;
            acc_hit_q   <= 1'b0;
            acc_rd_q    <= 1'b0;
            acc_off_q   <= 4'd0;
            acc_empty_q <= 1'b0;
            rdata_q     <= '0;
            odev_q      <= '0;
            strobe_q    <= '0;
            underflow_q <= 1'b0;
            for (int k = 0; k < NUM_IDEV; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
`ifdef HB_IODEV_IRQ_EN
            mask_q <= '0;
            irq_q  <= 1'b0;
`endif
        end else begin
            in_access_q <= in_access_d;
            acc_hit_q   <= acc_hit_d;
            acc_rd_q    <= acc_rd_d;
            acc_off_q   <= acc_off_d;
            acc_empty_q <= acc_empty_d;
            rdata_q     <= rdata_d;
            odev_q      <= odev_d;
            strobe_q    <= strobe_d;
            underflow_q <= underflow_d;
            for (int k = 0; k < NUM_IDEV; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
            end
`ifdef HB_IODEV_IRQ_EN
            mask_q <= mask_d;
            irq_q  <= irq_d;
`endif
        end
    end

    // FIFO storage has no reset; the pointers alone define occupancy.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end
endmodule

// File: tb/tb_hb_iodev_ctrl.sv
// Directed self-checking bench for hb_iodev_ctrl with default parameters.
module tb_hb_iodev_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] io_address = 12'h000;
    logic        csram_bar = 1'b1;
    logic        weram_bar = 1'b1;
    logic        bootloader_done = 1'b1;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        rdata_oe;
    logic        ram_sel;
    logic [23:0] odev_data;
    logic [2:0]  odev_strobe;
    logic [7:0]  idev_data = 8'h00;
    logic [0:0]  idev_valid = 1'b0;
    logic [0:0]  idev_ready;
`ifdef HB_IODEV_IRQ_EN
    logic        irq;
`endif
    int nvec = 0;
    int nerr = 0;

    hb_iodev_ctrl dut (
        .clk(clk), .rst(rst), .io_address(io_address), .csram_bar(csram_bar),
        .weram_bar(weram_bar), .bootloader_done(bootloader_done), .wdata(wdata),
        .rdata(rdata), .rdata_oe(rdata_oe), .ram_sel(ram_sel), .odev_data(odev_data),
        .odev_strobe(odev_strobe), .idev_data(idev_data), .idev_valid(idev_valid),
        .idev_ready(idev_ready)
`ifdef HB_IODEV_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic acc_start(input logic [11:0] a, input logic rd, input logic [7:0] d);
        @(negedge clk);
        io_address = a; weram_bar = rd; wdata = d; csram_bar = 1'b0;
        #1;
    endtask

    task automatic acc_stop();
        @(negedge clk);
        csram_bar = 1'b1; weram_bar = 1'b1;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        acc_start(a, 1'b0, d);
        acc_stop();
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [7:0] e);
        acc_start(a, 1'b1, 8'h00);
        chk(tag, rdata, e);
        chk({tag, "_oe"}, rdata_oe, 1'b1);
        acc_stop();
    endtask

    initial begin
        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_odev", odev_data, 24'h000000);
        chk("rst_strobe", odev_strobe, 3'b000);
        chk("rst_ready", idev_ready, 1'b1);
        chk("rst_ramsel", ram_sel, 1'b0);
        rd_chk("rst_status", 12'hFFF, 8'h00);

        // 2: output register write
        acc_start(12'hFF1, 1'b0, 8'hA5);
        chk("wr_ramsel", ram_sel, 1'b0);
        chk("wr_oe", rdata_oe, 1'b0);
        acc_stop();
        chk("wr_odev1", odev_data, 24'h00A500);
        chk("wr_strobe", odev_strobe, 3'b010);
        @(negedge clk);
        #1;
        chk("wr_strobe_off", odev_strobe, 3'b000);
        rd_chk("rb_odev1", 12'hFF1, 8'hA5);
        rd_chk("rb_odev2", 12'hFF2, 8'h00);
        wr(12'hFF3, 8'h77);
        chk("unmapped_wr", odev_data, 24'h00A500);
        rd_chk("rb_unmapped", 12'hFF3, 8'h00);
        wr(12'hFFE, 8'h55);
`ifndef HB_IODEV_IRQ_EN
        rd_chk("rb_off14", 12'hFFE, 8'h00);
`else
        wr(12'hFFE, 8'h00);
`endif

        // 3: fill FIFO to full, then pop and refill
        @(negedge clk);
        idev_valid = 1'b1; idev_data = 8'h11;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            idev_data = 8'h11 + 8'(i);
        end
        @(negedge clk);
        idev_data = 8'h15;
        #1;
        chk("full_ready", idev_ready, 1'b0);
        rd_chk("status_ne", 12'hFFF, 8'h01);
        rd_chk("pop_11", 12'hFF8, 8'h11);
        @(negedge clk);
        #1;
        chk("ready_back", idev_ready, 1'b1);
        @(negedge clk);
        idev_valid = 1'b0;
        #1;
        chk("refull_ready", idev_ready, 1'b0);
        rd_chk("pop_12", 12'hFF8, 8'h12);
        rd_chk("pop_13", 12'hFF8, 8'h13);
        rd_chk("pop_14", 12'hFF8, 8'h14);
        rd_chk("pop_15", 12'hFF8, 8'h15);
        rd_chk("status_empty", 12'hFFF, 8'h00);

        // 4: underflow
        rd_chk("uflow_rd", 12'hFF8, 8'h00);
        rd_chk("uflow_status", 12'hFFF, 8'h80);
        wr(12'hFFF, 8'h80);
        rd_chk("uflow_clr", 12'hFFF, 8'h00);

        // 5: long read, single pop, push on the pop edge
        @(negedge clk);
        idev_valid = 1'b1; idev_data = 8'h21;
        @(negedge clk);
        idev_valid = 1'b0;
        acc_start(12'hFF8, 1'b1, 8'h00);
        chk("long_c1", rdata, 8'h21);
        @(negedge clk);
        #1;
        chk("long_c2", rdata, 8'h21);
        @(negedge clk);
        #1;
        chk("long_c3", rdata, 8'h21);
        chk("long_oe", rdata_oe, 1'b1);
        @(negedge clk);
        csram_bar = 1'b1; weram_bar = 1'b1;
        idev_valid = 1'b1; idev_data = 8'h22;
        @(negedge clk);
        idev_valid = 1'b0;
        rd_chk("long_status", 12'hFFF, 8'h01);
        rd_chk("long_next", 12'hFF8, 8'h22);
        rd_chk("long_empty", 12'hFFF, 8'h00);

        // 6: boot copy routes everything to RAM
        @(negedge clk);
        bootloader_done = 1'b0;
        acc_start(12'hFF0, 1'b0, 8'h3C);
        chk("boot_ramsel", ram_sel, 1'b1);
        chk("boot_oe", rdata_oe, 1'b0);
        acc_stop();
        chk("boot_odev", odev_data, 24'h00A500);
        chk("boot_strobe", odev_strobe, 3'b000);
        acc_start(12'hFF1, 1'b1, 8'h00);
        chk("boot_rd_oe", rdata_oe, 1'b0);
        chk("boot_rd_data", rdata, 8'h00);
        acc_stop();
        bootloader_done = 1'b1;
        acc_start(12'h123, 1'b1, 8'h00);
        chk("ram_ramsel", ram_sel, 1'b1);
        chk("ram_oe", rdata_oe, 1'b0);
        chk("ram_data", rdata, 8'h00);
        acc_stop();
        chk("idle_ramsel", ram_sel, 1'b0);

`ifdef HB_IODEV_IRQ_EN
        wr(12'hFFE, 8'h01);
        rd_chk("mask_rb", 12'hFFE, 8'h01);
        chk("irq_idle", irq, 1'b0);
        @(negedge clk);
        idev_valid = 1'b1; idev_data = 8'h33;
        @(negedge clk);
        idev_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("irq_set", irq, 1'b1);
        rd_chk("irq_pop", 12'hFF8, 8'h33);
        @(negedge clk);
        #1;
        chk("irq_hold", irq, 1'b1);
        @(negedge clk);
        #1;
        chk("irq_clr", irq, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
